// File: rtl/or_merge_arbiter.sv
// Sequenced OR-merge of N_REQ requester contributions into one WIDTH-bit result.
// Each frame clears the accumulator, takes one round-robin grant per requester, then offers the result.
//
// state      | meaning
// ST_IDLE    | waiting for start, accumulator holds the last result
// ST_COLLECT | granting one unserved valid requester per cycle
// ST_DONE    | result offered on out_valid/out_data until out_ready
module or_merge_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_REQ-1:0]         in_valid,
  input  logic [N_REQ*WIDTH-1:0]   in_data,
  output logic [N_REQ-1:0]         in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [N_REQ-1:0]   served_q;
  logic [PTR_W-1:0]   rr_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [WIDTH-1:0]   grant_data;
  logic [PTR_W-1:0]   rr_d;
  logic               all_served;

  // Abort suppresses the grant so nothing is consumed in the abort cycle.
  always_comb begin
    elig      = (state_q == ST_COLLECT && !abort) ? (in_valid & ~served_q) : '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!grant_any && elig[k] && (((int'(rr_q) + i) % N_REQ) == k)) begin
          grant[k]  = 1'b1;
          grant_idx = PTR_W'(k);
          grant_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) grant_data = grant_data | in_data[k*WIDTH +: WIDTH];
    end
  end

  assign rr_d       = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  assign all_served = &(served_q | grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      served_q    <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= ST_IDLE;
      served_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_COLLECT;
            acc_q    <= '0;
            served_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (grant_any) begin
            acc_q    <= acc_q | grant_data;
            served_q <= served_q | grant;
            rr_q     <= rr_d;
            if (all_served) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = grant;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_or_merge_arbiter.sv
// Directed scenarios plus a randomized run against a frame-level model of the OR-merge arbiter.
module tb_or_merge_arbiter;
  localparam int W = 8;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;

  // Frame-level model: phase 0 idle, 1 collecting, 2 result offered.
  int       m_phase;
  logic [W-1:0] m_acc;
  bit       m_served [N];
  int       m_rr;

  or_merge_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_phase = 0;
    m_acc   = '0;
    m_rr    = 0;
    foreach (m_served[k]) m_served[k] = 1'b0;
  endfunction

  function automatic int exp_grant();
    if (m_phase != 1 || abort) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_rr + i) % N;
      if (in_valid[k] && !m_served[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    g = exp_grant();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic void model_update();
    int g;
    int cnt;
    if (!rst_n) begin
      model_reset();
    end else if (abort) begin
      m_phase = 0;
      foreach (m_served[k]) m_served[k] = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_acc   = '0;
        foreach (m_served[k]) m_served[k] = 1'b0;
      end
    end else if (m_phase == 1) begin
      g = exp_grant();
      if (g >= 0) begin
        m_acc       = m_acc | in_data[g*W +: W];
        m_served[g] = 1'b1;
        m_rr        = (g + 1) % N;
        cnt = 0;
        foreach (m_served[k]) cnt += int'(m_served[k]);
        if (cnt == N) m_phase = 2;
      end
    end else begin
      if (out_ready) m_phase = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = N'($urandom); in_data = N*W'($urandom); start = 1'($urandom);
    abort = 1'($urandom); out_ready = 1'($urandom);
    #12;
    model_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got %h want 00", out_data); end
    vectors++; if (in_ready !== 3'b000) begin miscompares++; $display("FAIL reset_in_ready got %b want 000", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0; in_valid = '1;
    rst_n = 1'b1;
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_busy got %0b want 0", busy); end
    vectors++; if (in_ready !== 3'b000) begin miscompares++; $display("FAIL reset_release_in_ready got %b want 000", in_ready); end
  endtask

  task automatic test_basic_frame();
    in_valid = 3'b111; in_data = {8'h80, 8'h10, 8'h01};
    start = 1'b1; tick(); start = 1'b0; #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %0b want 1", busy); end
    vectors++; if (in_ready !== 3'b001) begin miscompares++; $display("FAIL basic_grant1 got %b want 001", in_ready); end
    tick(); #1;
    vectors++; if (in_ready !== 3'b010) begin miscompares++; $display("FAIL basic_grant2 got %b want 010", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %0b want 0", out_valid); end
    tick(); #1;
    vectors++; if (in_ready !== 3'b100) begin miscompares++; $display("FAIL basic_grant3 got %b want 100", in_ready); end
    tick(); #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid got %0b want 1", out_valid); end
    vectors++; if (out_data !== 8'h91) begin miscompares++; $display("FAIL basic_out_data got %h want 91", out_data); end
    vectors++; if (in_ready !== 3'b000) begin miscompares++; $display("FAIL basic_done_ready got %b want 000", in_ready); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_round_robin_stall();
    in_valid = 3'b100; in_data = {8'h0F, 8'h00, 8'hF0};
    start = 1'b1; tick(); start = 1'b0; #1;
    vectors++; if (in_ready !== 3'b100) begin miscompares++; $display("FAIL rr_grant_k2 got %b want 100", in_ready); end
    tick(); #1;
    vectors++; if (in_ready !== 3'b000) begin miscompares++; $display("FAIL rr_served_stall got %b want 000", in_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rr_stall_busy got %0b want 1", busy); end
    tick();
    in_valid = 3'b111; #1;
    vectors++; if (in_ready !== 3'b001) begin miscompares++; $display("FAIL rr_grant_k0 got %b want 001", in_ready); end
    tick(); #1;
    vectors++; if (in_ready !== 3'b010) begin miscompares++; $display("FAIL rr_grant_k1 got %b want 010", in_ready); end
    tick(); #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rr_out_valid got %0b want 1", out_valid); end
    vectors++; if (out_data !== 8'hFF) begin miscompares++; $display("FAIL rr_out_data got %h want ff", out_data); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_data = N*W'($urandom);
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_hold cycle %0d got %0b want 1", c, out_valid); end
      vectors++; if (out_data !== 8'hFF) begin miscompares++; $display("FAIL bp_data_hold cycle %0d got %h want ff", c, out_data); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid got %0b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_release_busy got %0b want 0", busy); end
  endtask

  task automatic test_abort();
    in_valid = 3'b111; in_data = {8'h08, 8'h04, 8'h02};
    start = 1'b1; tick(); start = 1'b0; #1;
    vectors++; if (in_ready !== 3'b100) begin miscompares++; $display("FAIL abort_first_grant got %b want 100", in_ready); end
    tick();
    abort = 1'b1; #1;
    vectors++; if (in_ready !== 3'b000) begin miscompares++; $display("FAIL abort_cycle_ready got %b want 000", in_ready); end
    tick(); abort = 1'b0; #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %0b want 0", busy); end
    vectors++; if (out_data !== 8'h08) begin miscompares++; $display("FAIL abort_acc_kept got %h want 08", out_data); end
    start = 1'b1; tick(); start = 1'b0; #1;
    vectors++; if (in_ready !== 3'b001) begin miscompares++; $display("FAIL abort_refill_k0 got %b want 001", in_ready); end
    tick(); #1;
    vectors++; if (in_ready !== 3'b010) begin miscompares++; $display("FAIL abort_refill_k1 got %b want 010", in_ready); end
    tick(); #1;
    vectors++; if (in_ready !== 3'b100) begin miscompares++; $display("FAIL abort_refill_k2 got %b want 100", in_ready); end
    tick(); #1;
    vectors++; if (out_data !== 8'h0E || out_valid !== 1'b1) begin miscompares++; $display("FAIL abort_refill_result got %h/%0b want 0e/1", out_data, out_valid); end
    out_ready = 1'b1; abort = 1'b1; tick(); out_ready = 1'b0; #1;
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_in_done got valid %0b busy %0b want 0/0", out_valid, busy); end
    start = 1'b1; tick(); start = 1'b0; abort = 1'b0; #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_start_idle got busy %0b want 0", busy); end
  endtask

  task automatic test_async_reset();
    in_valid = 3'b111; in_data = {8'h08, 8'h04, 8'h02};
    start = 1'b1; tick(); start = 1'b0; #1;
    vectors++; if (in_ready !== 3'b001) begin miscompares++; $display("FAIL async_pre_grant got %b want 001", in_ready); end
    tick(); #2;
    rst_n = 1'b0; #1;
    model_reset();
    vectors++; if (out_data !== 8'h00 || in_ready !== 3'b000 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL async_clear got data %h ready %b busy %0b valid %0b want 00/000/0/0", out_data, in_ready, busy, out_valid);
    end
    start = 1'b1; tick(); start = 1'b0; #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_start_ignored got busy %0b want 0", busy); end
    #2; rst_n = 1'b1;
    tick(); #1;
    vectors++; if (busy !== 1'b0 || in_ready !== 3'b000) begin miscompares++; $display("FAIL async_release got busy %0b ready %b want 0/000", busy, in_ready); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      in_valid  = N'($urandom);
      in_data   = N*W'({$urandom, $urandom});
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 24) == 0);
      out_ready = 1'($urandom);
      #1;
      vectors++; if (in_ready !== exp_ready()) begin miscompares++; $display("FAIL rand_in_ready cycle %0d got %b want %b", c, in_ready, exp_ready()); end
      vectors++; if (out_valid !== (m_phase == 2)) begin miscompares++; $display("FAIL rand_out_valid cycle %0d got %0b want %0b", c, out_valid, (m_phase == 2)); end
      vectors++; if (out_data !== m_acc) begin miscompares++; $display("FAIL rand_out_data cycle %0d got %h want %h", c, out_data, m_acc); end
      vectors++; if (busy !== (m_phase != 0)) begin miscompares++; $display("FAIL rand_busy cycle %0d got %0b want %0b", c, busy, (m_phase != 0)); end
      tick();
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    in_valid = '0; in_data = '0;
    model_reset();
    test_reset();
    test_basic_frame();
    test_round_robin_stall();
    test_back_pressure();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
